// File: rtl/add_subt_arbiter.sv
// -----------------------------------------------------------------------------
// add_subt_arbiter
//
// Shares one add/subtract unit between three CORDIC requesters (X, Y, Z).
// A round-robin Moore FSM (IDLE -> LAUNCH -> WAIT -> DELIVER) grants one
// requester at a time, registers its operands and operation towards the adder,
// waits for the adder result and holds it for the granted requester until that
// requester acknowledges it. Every output is driven from a register.
//
// Optional feature (macro TIMEOUT_ARB_EN):
//   When defined, a watchdog counts WAIT cycles. After TIMEOUT_CYCLES cycles
//   with no ready_add_subt, the transaction is closed with err_o=1 and a zero
//   result. When undefined, WAIT is unbounded and err_o is tied to 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   req_i[2:0]     in   per-requester request (0:X, 1:Y, 2:Z)
//   data_a_i       in   operand A, requester k at [k*W +: W]
//   data_b_i       in   operand B, same packing
//   op_i[2:0]      in   per-requester operation (0 add, 1 subtract)
//   ack_i[2:0]     in   per-requester acknowledge of the delivered result
//   ready_add_subt in   adder result valid
//   result_i       in   adder result
//   beg_add_subt   out  one-cycle start strobe to the adder
//   ack_add_subt   out  one-cycle "result taken" strobe to the adder
//   op_a_o, op_b_o out  operands to the adder
//   add_subt_o     out  operation to the adder
//   gnt_o[2:0]     out  one-hot grant
//   done_o[2:0]    out  one-hot result valid
//   result_o       out  result for the granted requester
//   err_o          out  watchdog timeout flag
// -----------------------------------------------------------------------------
module add_subt_arbiter #(
    parameter int W              = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     req_i,
    input  logic [3*W-1:0] data_a_i,
    input  logic [3*W-1:0] data_b_i,
    input  logic [2:0]     op_i,
    input  logic [2:0]     ack_i,
    input  logic           ready_add_subt,
    input  logic [W-1:0]   result_i,
    output logic           beg_add_subt,
    output logic           ack_add_subt,
    output logic [W-1:0]   op_a_o,
    output logic [W-1:0]   op_b_o,
    output logic           add_subt_o,
    output logic [2:0]     gnt_o,
    output logic [2:0]     done_o,
    output logic [W-1:0]   result_o,
    output logic           err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t       state_r, state_s;
    logic [1:0]   last_grant_r, last_grant_s;
    logic [1:0]   gidx_r, gidx_s;
    logic [W-1:0] op_a_r, op_a_s;
    logic [W-1:0] op_b_r, op_b_s;
    logic         add_subt_r, add_subt_s;
    logic [2:0]   gnt_r, gnt_s;
    logic [2:0]   done_r, done_s;
    logic [W-1:0] result_r, result_s;
    logic         beg_r, beg_s;
    logic         ack_r, ack_s;

    logic [1:0]   pick_s;
    logic         pick_valid_s;
    logic [1:0]   cand_s;
    logic [W-1:0] sel_a_s, sel_b_s;
    logic         sel_op_s;
    logic         timeout_s;

    // Successor of a requester index in the round-robin ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] k);
        logic [1:0] n;
        case (k)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] k);
        logic [2:0] v;
        case (k)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Round-robin pick: scan starting one past the last served requester.
    always_comb begin
        pick_s       = 2'd0;
        pick_valid_s = 1'b0;
        cand_s       = next_idx(last_grant_r);
        for (int i = 0; i < 3; i++) begin
            if (!pick_valid_s && req_i[cand_s]) begin
                pick_s       = cand_s;
                pick_valid_s = 1'b1;
            end else begin
                pick_s       = pick_s;
            end
            cand_s = next_idx(cand_s);
        end
    end

    // Operand/operation mux for the picked requester.
    always_comb begin
        case (pick_s)
            2'd1: begin
                sel_a_s  = data_a_i[W +: W];
                sel_b_s  = data_b_i[W +: W];
                sel_op_s = op_i[1];
            end
            2'd2: begin
                sel_a_s  = data_a_i[2*W +: W];
                sel_b_s  = data_b_i[2*W +: W];
                sel_op_s = op_i[2];
            end
            default: begin
                sel_a_s  = data_a_i[0 +: W];
                sel_b_s  = data_b_i[0 +: W];
                sel_op_s = op_i[0];
            end
        endcase
    end

    // Next-state and next-output logic; registered values hold by default,
    // the adder strobes default low so they only ever last one cycle.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        gidx_s       = gidx_r;
        op_a_s       = op_a_r;
        op_b_s       = op_b_r;
        add_subt_s   = add_subt_r;
        gnt_s        = gnt_r;
        done_s       = done_r;
        result_s     = result_r;
        beg_s        = 1'b0;
        ack_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gidx_s     = pick_s;
                    op_a_s     = sel_a_s;
                    op_b_s     = sel_b_s;
                    add_subt_s = sel_op_s;
                    gnt_s      = idx_to_onehot(pick_s);
                    state_s    = ST_LAUNCH;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                beg_s   = 1'b1;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A real result wins over a watchdog expiry in the same cycle.
                if (ready_add_subt) begin
                    result_s = result_i;
                    ack_s    = 1'b1;
                    done_s   = gnt_r;
                    state_s  = ST_DELIVER;
                end else if (timeout_s) begin
                    result_s = '0;
                    ack_s    = 1'b1;
                    done_s   = gnt_r;
                    state_s  = ST_DELIVER;
                end else begin
                    state_s  = ST_WAIT;
                end
            end
            ST_DELIVER: begin
                // Only the granted requester's acknowledge closes the transaction.
                if ((ack_i & gnt_r) != 3'b000) begin
                    gnt_s        = 3'b000;
                    done_s       = 3'b000;
                    last_grant_s = gidx_r;
                    state_s      = ST_IDLE;
                end else begin
                    state_s      = ST_DELIVER;
                end
            end
            default: begin
                gnt_s   = 3'b000;
                done_s  = 3'b000;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 2'd2;
            gidx_r       <= 2'd0;
            op_a_r       <= '0;
            op_b_r       <= '0;
            add_subt_r   <= 1'b0;
            gnt_r        <= 3'b000;
            done_r       <= 3'b000;
            result_r     <= '0;
            beg_r        <= 1'b0;
            ack_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            gidx_r       <= gidx_s;
            op_a_r       <= op_a_s;
            op_b_r       <= op_b_s;
            add_subt_r   <= add_subt_s;
            gnt_r        <= gnt_s;
            done_r       <= done_s;
            result_r     <= result_s;
            beg_r        <= beg_s;
            ack_r        <= ack_s;
        end
    end

`ifdef TIMEOUT_ARB_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_r, wd_cnt_s;
    logic             err_r;

    // Watchdog: counts WAIT cycles without ready; expires on the last one.
    always_comb begin
        timeout_s = 1'b0;
        wd_cnt_s  = '0;
        if ((state_r == ST_WAIT) && !ready_add_subt) begin
            if (wd_cnt_r == CNT_LAST) begin
                timeout_s = 1'b1;
                wd_cnt_s  = '0;
            end else begin
                wd_cnt_s  = wd_cnt_r + 1'b1;
            end
        end else begin
            wd_cnt_s  = '0;
        end
    end

    // Watchdog counter and error flag; the flag lives until DELIVER is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= '0;
            err_r    <= 1'b0;
        end else begin
            wd_cnt_r <= wd_cnt_s;
            if (timeout_s) begin
                err_r <= 1'b1;
            end else if ((state_r == ST_DELIVER) && (state_s == ST_IDLE)) begin
                err_r <= 1'b0;
            end
        end
    end

    assign err_o = err_r;
`else
    assign timeout_s = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign beg_add_subt = beg_r;
    assign ack_add_subt = ack_r;
    assign op_a_o       = op_a_r;
    assign op_b_o       = op_b_r;
    assign add_subt_o   = add_subt_r;
    assign gnt_o        = gnt_r;
    assign done_o       = done_r;
    assign result_o     = result_r;

endmodule

// File: tb/tb_add_subt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_subt_arbiter
//
// Self-checking bench for add_subt_arbiter. The bench plays the shared adder
// and the three requesters. A reference model (last served requester plus a
// round-robin pick computed with modulo arithmetic) predicts grants, latched
// operands, strobes and delivered results.
// -----------------------------------------------------------------------------
module tb_add_subt_arbiter;

    localparam int W  = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [2:0]     req_i;
    logic [3*W-1:0] data_a_i;
    logic [3*W-1:0] data_b_i;
    logic [2:0]     op_i;
    logic [2:0]     ack_i;
    logic           ready_add_subt;
    logic [W-1:0]   result_i;
    logic           beg_add_subt;
    logic           ack_add_subt;
    logic [W-1:0]   op_a_o;
    logic [W-1:0]   op_b_o;
    logic           add_subt_o;
    logic [2:0]     gnt_o;
    logic [2:0]     done_o;
    logic [W-1:0]   result_o;
    logic           err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int last_g   = 2;

    always #5 clk = ~clk;

    add_subt_arbiter #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_i          (req_i),
        .data_a_i       (data_a_i),
        .data_b_i       (data_b_i),
        .op_i           (op_i),
        .ack_i          (ack_i),
        .ready_add_subt (ready_add_subt),
        .result_i       (result_i),
        .beg_add_subt   (beg_add_subt),
        .ack_add_subt   (ack_add_subt),
        .op_a_o         (op_a_o),
        .op_b_o         (op_b_o),
        .add_subt_o     (add_subt_o),
        .gnt_o          (gnt_o),
        .done_o         (done_o),
        .result_o       (result_o),
        .err_o          (err_o)
    );

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round robin: first requesting index after the last served one.
    function automatic int rr_pick(input logic [2:0] req, input int last);
        for (int i = 1; i <= 3; i++) begin
            int k;
            k = (last + i) % 3;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic scramble_inputs();
        req_i    = 3'($urandom_range(0, 7));
        data_a_i = {$urandom, $urandom, $urandom};
        data_b_i = {$urandom, $urandom, $urandom};
        op_i     = 3'($urandom_range(0, 7));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        last_g = 2;
    endtask

    // One full transaction; req_i must be non-zero and the DUT idle on entry.
    task automatic run_txn(input int delay, input logic [W-1:0] res,
                           input bit scramble, output int winner);
        int k;
        logic [W-1:0] ea, eb;
        logic eop;
        logic [2:0] g1;
        k   = rr_pick(req_i, last_g);
        if (k < 0) k = 0;
        ea  = data_a_i[k*W +: W];
        eb  = data_b_i[k*W +: W];
        eop = op_i[k];
        g1  = 3'b001 << k;

        tick();
        n_checks++;
        if ({gnt_o, op_a_o, op_b_o, add_subt_o, beg_add_subt, done_o} !== {g1, ea, eb, eop, 1'b0, 3'b000}) begin
            n_fail++;
            $display("FAIL grant_latch: got gnt=%b a=%h b=%h op=%b beg=%b done=%b, want gnt=%b a=%h b=%h op=%b beg=0 done=000",
                     gnt_o, op_a_o, op_b_o, add_subt_o, beg_add_subt, done_o, g1, ea, eb, eop);
        end
        if (scramble) scramble_inputs();

        tick();
        n_checks++;
        if ({beg_add_subt, ack_add_subt} !== 2'b10) begin
            n_fail++;
            $display("FAIL beg_strobe: got beg=%b ack_as=%b, want beg=1 ack_as=0", beg_add_subt, ack_add_subt);
        end

        for (int d = 0; d < delay; d++) begin
            if (scramble) scramble_inputs();
            tick();
            n_checks++;
            if ({beg_add_subt, ack_add_subt, done_o, err_o} !== 6'b000000) begin
                n_fail++;
                $display("FAIL wait_quiet: got beg=%b ack_as=%b done=%b err=%b, want all 0",
                         beg_add_subt, ack_add_subt, done_o, err_o);
            end
        end

        ready_add_subt = 1'b1;
        result_i       = res;
        tick();
        ready_add_subt = 1'b0;
        result_i       = $urandom;
        n_checks++;
        if ({done_o, result_o, ack_add_subt, gnt_o, op_a_o, op_b_o, add_subt_o} !== {g1, res, 1'b1, g1, ea, eb, eop}) begin
            n_fail++;
            $display("FAIL deliver: got done=%b res=%h ack_as=%b gnt=%b a=%h b=%h op=%b, want done=%b res=%h ack_as=1 gnt=%b a=%h b=%h op=%b",
                     done_o, result_o, ack_add_subt, gnt_o, op_a_o, op_b_o, add_subt_o, g1, res, g1, ea, eb, eop);
        end

        // Stray adder ready and non-granted acknowledges must not disturb DELIVER.
        ready_add_subt = 1'b1;
        ack_i          = ~g1;
        tick();
        ready_add_subt = 1'b0;
        ack_i          = 3'b000;
        n_checks++;
        if ({done_o, result_o, ack_add_subt, gnt_o} !== {g1, res, 1'b0, g1}) begin
            n_fail++;
            $display("FAIL deliver_hold: got done=%b res=%h ack_as=%b gnt=%b, want done=%b res=%h ack_as=0 gnt=%b",
                     done_o, result_o, ack_add_subt, gnt_o, g1, res, g1);
        end

        // Acknowledge; any pending request must wait one cycle in IDLE.
        ack_i = g1;
        tick();
        ack_i = 3'b000;
        n_checks++;
        if ({gnt_o, done_o, beg_add_subt, err_o} !== 7'b0000000) begin
            n_fail++;
            $display("FAIL release: got gnt=%b done=%b beg=%b err=%b, want all 0", gnt_o, done_o, beg_add_subt, err_o);
        end
        last_g = k;
        winner = k;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({beg_add_subt, ack_add_subt, op_a_o, op_b_o, add_subt_o, gnt_o, done_o, result_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got beg=%b ack_as=%b a=%h b=%h op=%b gnt=%b done=%b res=%h err=%b, want all 0",
                     beg_add_subt, ack_add_subt, op_a_o, op_b_o, add_subt_o, gnt_o, done_o, result_o, err_o);
        end
    endtask

    task automatic test_basic();
        int w;
        req_i    = 3'b001;
        data_a_i = {32'h0, 32'h0, 32'h3F80_0000};
        data_b_i = {32'h0, 32'h0, 32'h4000_0000};
        op_i     = 3'b000;
        run_txn(5, 32'h4040_0000, 1'b0, w);
        req_i = 3'b000;
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL basic_winner: got %0d, want 0", w);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[4] = '{0, 1, 2, 0};
        int w;
        apply_reset();
        req_i    = 3'b111;
        data_a_i = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        data_b_i = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        op_i     = 3'b101;
        for (int i = 0; i < 4; i++) begin
            run_txn(i, 32'hD000_0000 + 32'(i), 1'b0, w);
            n_checks++;
            if (w != exp_order[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d, want %0d", i, w, exp_order[i]);
            end
        end
        req_i = 3'b000;
    endtask

    task automatic test_hold_stable();
        int w;
        req_i    = 3'b010;
        data_a_i = {$urandom, $urandom, $urandom};
        data_b_i = {$urandom, $urandom, $urandom};
        op_i     = 3'b010;
        run_txn(4, 32'h1234_5678, 1'b1, w);
        req_i = 3'b000;
        n_checks++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL hold_winner: got %0d, want 1", w);
        end
    endtask

    task automatic test_reset_mid_wait();
        int w;
        req_i = 3'b001;
        tick();
        tick();
        tick();
        reset          = 1'b1;
        ready_add_subt = 1'b1;
        result_i       = 32'hDEAD_BEEF;
        tick();
        reset  = 1'b0;
        req_i  = 3'b000;
        last_g = 2;
        n_checks++;
        if ({beg_add_subt, ack_add_subt, op_a_o, op_b_o, add_subt_o, gnt_o, done_o, result_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL abort_state: got beg=%b ack_as=%b a=%h b=%h op=%b gnt=%b done=%b res=%h err=%b, want all 0",
                     beg_add_subt, ack_add_subt, op_a_o, op_b_o, add_subt_o, gnt_o, done_o, result_o, err_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({ack_add_subt, done_o, gnt_o, result_o} !== '0) begin
                n_fail++;
                $display("FAIL abort_ignore_ready: got ack_as=%b done=%b gnt=%b res=%h, want all 0",
                         ack_add_subt, done_o, gnt_o, result_o);
            end
        end
        ready_add_subt = 1'b0;
        req_i          = 3'b011;
        run_txn(1, 32'h0BAD_F00D, 1'b0, w);
        req_i = 3'b000;
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL abort_first_winner: got %0d, want 0", w);
        end
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 40; i++) begin
            scramble_inputs();
            req_i = 3'($urandom_range(1, 7));
            run_txn($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)), w);
        end
        req_i = 3'b000;
    endtask

    task automatic test_timeout();
        req_i = 3'b100;
        tick();
        tick();
        req_i = 3'b000;
`ifdef TIMEOUT_ARB_EN
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            n_checks++;
            if ({err_o, ack_add_subt, done_o} !== 5'b00000) begin
                n_fail++;
                $display("FAIL to_early: got err=%b ack_as=%b done=%b, want 0", err_o, ack_add_subt, done_o);
            end
        end
        tick();
        n_checks++;
        if ({err_o, ack_add_subt, done_o, result_o} !== {1'b1, 1'b1, 3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL to_fire: got err=%b ack_as=%b done=%b res=%h, want err=1 ack_as=1 done=100 res=0",
                     err_o, ack_add_subt, done_o, result_o);
        end
        tick();
        n_checks++;
        if ({err_o, ack_add_subt, done_o} !== {1'b1, 1'b0, 3'b100}) begin
            n_fail++;
            $display("FAIL to_hold: got err=%b ack_as=%b done=%b, want err=1 ack_as=0 done=100", err_o, ack_add_subt, done_o);
        end
`else
        for (int i = 0; i < 3 * TO; i++) begin
            tick();
            n_checks++;
            if ({err_o, ack_add_subt, done_o} !== 5'b00000) begin
                n_fail++;
                $display("FAIL no_timeout: got err=%b ack_as=%b done=%b, want 0", err_o, ack_add_subt, done_o);
            end
        end
        ready_add_subt = 1'b1;
        result_i       = 32'h7777_0000;
        tick();
        ready_add_subt = 1'b0;
        n_checks++;
        if ({err_o, ack_add_subt, done_o, result_o} !== {1'b0, 1'b1, 3'b100, 32'h7777_0000}) begin
            n_fail++;
            $display("FAIL late_ready: got err=%b ack_as=%b done=%b res=%h, want err=0 ack_as=1 done=100 res=77770000",
                     err_o, ack_add_subt, done_o, result_o);
        end
`endif
        ack_i = 3'b100;
        tick();
        ack_i  = 3'b000;
        last_g = 2;
        n_checks++;
        if ({err_o, done_o, gnt_o} !== 7'b0000000) begin
            n_fail++;
            $display("FAIL to_release: got err=%b done=%b gnt=%b, want 0", err_o, done_o, gnt_o);
        end
    endtask

    initial begin
        reset          = 1'b1;
        req_i          = 3'b000;
        data_a_i       = '0;
        data_b_i       = '0;
        op_i           = 3'b000;
        ack_i          = 3'b000;
        ready_add_subt = 1'b0;
        result_i       = '0;
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_hold_stable();
        test_reset_mid_wait();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
